// File: rtl/serdes_pkg.sv
// Shared types and helpers for the framed single-lane SerDes.
// Optional PRBS test traffic is enabled by SERDES_PRBS_EN (see serdes_lane).
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam logic FLAG_DATA = 1'b1;
    localparam logic FLAG_IDLE = 1'b0;

    // PRBS7 (x^7 + x^6 + 1): new bit enters at bit 0 and is the output bit.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/serdes_frame_rx.sv
// RX word aligner: serial shift window, HUNT/VERIFY/LOCKED state machine,
// lock/loss counters and registered word outputs. State is exported as rx_state.
module serdes_frame_rx
    import serdes_pkg::*;
#(
    parameter int                DATA_W    = 10,
    parameter logic [DATA_W-1:0] SYNC_WORD = 10'h17C,
    parameter int                LOCK_CNT  = 4,
    parameter int                LOSS_CNT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              serdes_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output rx_state_e         rx_state
);

    localparam int F  = DATA_W + 1;
    localparam int CW = $clog2(F);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(F - 1);
    localparam logic [GW-1:0] LOCK_V     = GW'(LOCK_CNT);
    localparam logic [BW-1:0] LOSS_V     = BW'(LOSS_CNT);

    logic [F-1:0]      win;
    logic [CW-1:0]     frm_cnt;
    logic [GW-1:0]     good_cnt;
    logic [BW-1:0]     bad_cnt;
    logic [GW-1:0]     good_inc;
    logic [BW-1:0]     bad_inc;
    logic              flag;
    logic [DATA_W-1:0] payload;
    logic              is_sync;
    logic              is_good;
    logic              at_boundary;

    assign flag        = win[F-1];
    assign payload     = win[DATA_W-1:0];
    assign is_sync     = (flag == FLAG_IDLE) && (payload == SYNC_WORD);
    assign is_good     = (flag == FLAG_DATA) || is_sync;
    assign at_boundary = (frm_cnt == FRAME_LAST);
    assign good_inc    = (good_cnt == {GW{1'b1}}) ? good_cnt : good_cnt + 1'b1;
    assign bad_inc     = (bad_cnt == {BW{1'b1}}) ? bad_cnt : bad_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            win      <= '0;
            frm_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            rx_state <= HUNT;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            win      <= {win[F-2:0], serdes_rx};
            frm_cnt  <= at_boundary ? '0 : frm_cnt + 1'b1;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_state)
                HUNT: begin
                    // The sync match is itself the first good frame; its boundary is now.
                    if (is_sync) begin
                        frm_cnt  <= '0;
                        good_cnt <= GW'(1);
                        bad_cnt  <= '0;
                        rx_state <= (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (at_boundary) begin
                        if (!is_good) begin
                            rx_state <= HUNT;
                        end else begin
                            good_cnt <= good_inc;
                            if (good_inc == LOCK_V) rx_state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (at_boundary) begin
                        if (is_good) begin
                            bad_cnt <= '0;
                            if (flag == FLAG_DATA) begin
                                rx_data  <= payload;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            rx_err  <= 1'b1;
                            bad_cnt <= bad_inc;
                            if (bad_inc == LOSS_V) rx_state <= HUNT;
                        end
                    end
                end
                default: rx_state <= HUNT;
            endcase
        end
    end

endmodule

// File: rtl/serdes_lane.sv
// Single-lane framed SerDes: TX serializer with valid/ready word input plus RX aligner.
// Define SERDES_PRBS_EN to add PRBS7 test traffic (prbs_mode, prbs_err_cnt).
module serdes_lane
    import serdes_pkg::*;
#(
    parameter int                DATA_W    = 10,
    parameter logic [DATA_W-1:0] SYNC_WORD = 10'h17C,
    parameter int                LOCK_CNT  = 4,
    parameter int                LOSS_CNT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serdes_tx,
    input  logic              serdes_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_locked,
    output logic              rx_err
`ifdef SERDES_PRBS_EN
    ,
    input  logic              prbs_mode,
    output logic [15:0]       prbs_err_cnt
`endif
);

    localparam int F  = DATA_W + 1;
    localparam int CW = $clog2(F);
    localparam logic [CW-1:0] FRAME_LAST = CW'(F - 1);

    // Handshake: a word moves when tx_valid && tx_ready at a rising edge;
    // tx_ready is high only in load cycles and never depends on tx_valid.
    logic          load;
    logic          tx_first;
    logic [CW-1:0] tx_cnt;
    logic [F-2:0]  tx_sr;
    logic [F-1:0]  tx_frame;
    rx_state_e     rx_state;

    assign load = !rst && enable && (tx_first || tx_cnt == FRAME_LAST);

`ifdef SERDES_PRBS_EN
    logic [6:0]        tx_lfsr;
    logic [6:0]        tx_lfsr_next;
    logic [DATA_W-1:0] tx_prbs_word;
    logic [6:0]        chk_lfsr;
    logic [6:0]        chk_lfsr_next;
    logic [DATA_W-1:0] chk_word;
    logic              chk_seeded;

    assign tx_ready = load && !prbs_mode;

    always_comb begin
        tx_lfsr_next = tx_lfsr;
        tx_prbs_word = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            tx_lfsr_next    = prbs7_step(tx_lfsr_next);
            tx_prbs_word[i] = tx_lfsr_next[0];
        end
    end

    always_comb begin
        chk_lfsr_next = chk_lfsr;
        chk_word      = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            chk_lfsr_next = prbs7_step(chk_lfsr_next);
            chk_word[i]   = chk_lfsr_next[0];
        end
    end

    always_comb begin
        tx_frame = {FLAG_IDLE, SYNC_WORD};
        if (prbs_mode)     tx_frame = {FLAG_DATA, tx_prbs_word};
        else if (tx_valid) tx_frame = {FLAG_DATA, tx_data};
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) tx_lfsr <= 7'h7F;
        else if (load && prbs_mode) tx_lfsr <= tx_lfsr_next;
    end

    // Checker seeds from the last 7 bits of the first data word, then free-runs.
    always_ff @(posedge clk) begin
        if (rst || !enable || !rx_locked || !prbs_mode) begin
            chk_seeded <= 1'b0;
            chk_lfsr   <= 7'h7F;
        end else if (rx_valid) begin
            chk_seeded <= 1'b1;
            chk_lfsr   <= chk_seeded ? chk_lfsr_next : rx_data[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prbs_err_cnt <= '0;
        end else if (enable && prbs_mode && rx_valid && chk_seeded &&
                     rx_data != chk_word && prbs_err_cnt != 16'hFFFF) begin
            prbs_err_cnt <= prbs_err_cnt + 16'd1;
        end
    end
`else
    assign tx_ready = load;

    always_comb begin
        tx_frame = {FLAG_IDLE, SYNC_WORD};
        if (tx_valid) tx_frame = {FLAG_DATA, tx_data};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            tx_first  <= 1'b1;
            tx_cnt    <= '0;
            tx_sr     <= '0;
            serdes_tx <= 1'b0;
        end else if (load) begin
            tx_first  <= 1'b0;
            tx_cnt    <= '0;
            serdes_tx <= tx_frame[F-1];
            tx_sr     <= tx_frame[F-2:0];
        end else begin
            if (tx_cnt != FRAME_LAST) tx_cnt <= tx_cnt + 1'b1;
            serdes_tx <= tx_sr[F-2];
            tx_sr     <= {tx_sr[F-3:0], 1'b0};
        end
    end

    serdes_frame_rx #(
        .DATA_W    (DATA_W),
        .SYNC_WORD (SYNC_WORD),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT)
    ) u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .serdes_rx (serdes_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .rx_state  (rx_state)
    );

    assign rx_locked = (rx_state == LOCKED);

endmodule

// File: tb/tb_serdes_lane.sv
// Loopback bench for serdes_lane: directed words, line inversion and bit-slip faults.
// PRBS checks are included when SERDES_PRBS_EN is defined.
module tb_serdes_lane;

    localparam int DATA_W = 10;
    localparam int F      = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              serdes_tx;
    logic              serdes_rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_locked;
    logic              rx_err;
`ifdef SERDES_PRBS_EN
    logic              prbs_mode;
    logic [15:0]       prbs_err_cnt;
`endif

    logic              tx_d1;
    bit                use_dly;
    bit                sb_on;
    int                inv_depth;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                valid_cnt = 0;
    int                err_cnt = 0;
    int                exp_lat;
    logic [DATA_W-1:0] exp_q[$];
    int                acc_q[$];

    serdes_lane dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serdes_tx (serdes_tx),
        .serdes_rx (serdes_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_locked (rx_locked),
        .rx_err    (rx_err)
`ifdef SERDES_PRBS_EN
        ,
        .prbs_mode    (prbs_mode),
        .prbs_err_cnt (prbs_err_cnt)
`endif
    );

    // clock / loopback channel
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tx_d1 <= serdes_tx;
    end

    assign serdes_rx = (use_dly ? tx_d1 : serdes_tx) ^ (inv_depth != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every rx_valid must match the oldest accepted word and its latency
    always @(negedge clk) begin
        if (rx_err) err_cnt++;
        if (rx_valid && sb_on) begin
            valid_cnt++;
            check("valid_only_when_locked", rx_locked, 1'b1);
            if (exp_q.size() == 0) begin
                check("spurious_rx_valid", rx_valid, 1'b0);
            end else begin
                check("rx_data", rx_data, exp_q.pop_front());
                check("latency", cyc - acc_q.pop_front(), exp_lat);
            end
        end
    end

    task automatic send_word(input logic [DATA_W-1:0] d, input bit track, input bit invert,
                             output int acc);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && n < 2 * F) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_seen", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        acc = cyc;
        if (track) begin
            exp_q.push_back(d);
            acc_q.push_back(cyc);
        end
        if (invert) begin
            fork
                begin
                    inv_depth++;
                    repeat (F) @(posedge clk);
                    #1;
                    inv_depth--;
                end
            join_none
        end
    endtask

    task automatic wait_lock(input string tag, input int budget, output int took);
        took = 0;
        while (!rx_locked && took < budget) begin
            @(negedge clk);
            took++;
        end
        check(tag, rx_locked, 1'b1);
    endtask

    initial begin
        int took;
        int a0;
        int a1;
        int first_acc;
        int n;
        rst       = 1'b1;
        enable    = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        use_dly   = 1'b0;
        sb_on     = 1'b1;
        inv_depth = 0;
        exp_lat   = F + 1;
`ifdef SERDES_PRBS_EN
        prbs_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // 1: reset values, then lock on idle frames only
        check("rst_serdes_tx", serdes_tx, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_locked", rx_locked, 1'b0);
        check("rst_rx_err", rx_err, 1'b0);
        check("rst_rx_data", rx_data, 10'h000);
        rst    = 1'b0;
        enable = 1'b1;
        wait_lock("t1_lock", 8 * F, took);
        check("t1_lock_time_window", (took >= 3 * F) && (took <= 6 * F), 1'b1);
        check("t1_no_rx_valid", valid_cnt, 0);

        // 2: two back-to-back words
        send_word(10'h3A5, 1'b1, 1'b0, a0);
        send_word(10'h05A, 1'b1, 1'b0, a1);
        check("t2_accept_spacing", a1 - a0, F);
        repeat (2 * F + 4) @(negedge clk);
        check("t2_rx_count", valid_cnt, 2);

        // 3: 20 words with tx_valid held
        send_word(10'd0, 1'b1, 1'b0, first_acc);
        for (int i = 1; i < 20; i++) send_word(DATA_W'(i), 1'b1, 1'b0, a1);
        check("t3_ready_duty", a1 - first_acc, 19 * F);
        repeat (2 * F + 4) @(negedge clk);
        check("t3_rx_count", valid_cnt, 22);
        check("t3_no_rx_err", err_cnt, 0);
        check("t3_queue_drained", exp_q.size(), 0);

        // 4: one inverted frame keeps lock, three drop it
        send_word(10'h155, 1'b0, 1'b1, a0);
        repeat (2 * F + 4) @(negedge clk);
        check("t4_single_err", err_cnt, 1);
        check("t4_lock_kept", rx_locked, 1'b1);
        send_word(10'h155, 1'b0, 1'b1, a0);
        send_word(10'h0F0, 1'b0, 1'b1, a0);
        send_word(10'h333, 1'b0, 1'b1, a0);
        repeat (F + 3) @(negedge clk);
        check("t4_triple_err", err_cnt, 4);
        check("t4_lock_lost", rx_locked, 1'b0);
        wait_lock("t4_relock", 10 * F, took);

        // 5: one extra bit of line delay forces a realignment
        use_dly = 1'b1;
        n = 0;
        while (rx_locked && n < 8 * F) begin
            @(negedge clk);
            n++;
        end
        check("t5_lock_lost", rx_locked, 1'b0);
        wait_lock("t5_relock", 12 * F, took);
        exp_lat = F + 2;
        send_word(10'h2AA, 1'b1, 1'b0, a0);
        repeat (2 * F + 4) @(negedge clk);
        check("t5_rx_count", valid_cnt, 23);

        // 6: enable drop mid-frame abandons the word
        send_word(10'h0F0, 1'b0, 1'b0, a0);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_rx_locked", rx_locked, 1'b0);
        check("dis_serdes_tx", serdes_tx, 1'b0);
        check("dis_tx_ready", tx_ready, 1'b0);
        check("dis_rx_data", rx_data, 10'h000);
        enable = 1'b1;
        wait_lock("dis_relock", 12 * F, took);
        send_word(10'h1C3, 1'b1, 1'b0, a0);
        repeat (2 * F + 4) @(negedge clk);
        check("dis_rx_count", valid_cnt, 24);

`ifdef SERDES_PRBS_EN
        // 7: PRBS traffic, one flipped payload bit in frame 51
        sb_on     = 1'b0;
        use_dly   = 1'b0;
        exp_lat   = F + 1;
        wait_lock("prbs_relock", 12 * F, took);
        prbs_mode = 1'b1;
        n    = 0;
        took = 0;
        while (n < 50 && took < 60 * F) begin
            @(negedge clk);
            took++;
            if (rx_valid) n++;
        end
        check("prbs_frames_seen", n, 50);
        check("prbs_clean", prbs_err_cnt, 16'd0);
        inv_depth++;
        @(posedge clk);
        #1;
        inv_depth--;
        repeat (150 * F) @(negedge clk);
        check("prbs_one_err", prbs_err_cnt, 16'd1);
        check("prbs_still_locked", rx_locked, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("prbs_rst_clear", prbs_err_cnt, 16'd0);
        rst = 1'b0;
`endif

        check("end_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
